// File: rtl/raw_stream_tx.sv
// Raw-domain video stream transmitter.
// Generates a pixel stream with programmable frame timing and a selectable test pattern.
// Ports:
//   clk, rstn           clock and asynchronous active-low reset
//   en_i                global advance enable; low freezes state, counters and LFSR
//   config_addr_i/data_i/config_en   register write bus (3-bit address, 16-bit data)
//   data_o, valid_o     pixel value and qualifier
//   frame_sync_o        pulse with the first pixel of a frame
//   line_sync_o         pulse with the first pixel of every line
//   frame_done_o        pulse with the last pixel of a frame
//   busy_o              high while the FSM is not idle
module raw_stream_tx #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEF_WIDTH  = 64,
  parameter int unsigned DEF_HEIGHT = 48,
  parameter int unsigned DEF_HBLANK = 16,
  parameter int unsigned DEF_VBLANK = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en_i,
  input  logic [2:0]            config_addr_i,
  input  logic [15:0]           config_data_i,
  input  logic                  config_en,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  frame_sync_o,
  output logic                  line_sync_o,
  output logic                  frame_done_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {StIdle, StActive, StHblank, StVblank} state_e;

  localparam logic [15:0] LfsrInit = 16'hACE1;

  state_e state_q, state_d;

  // Programmable registers
  logic [2:0]  ctrl_q;
  logic [15:0] width_q, height_q, hblank_q, vblank_q, seed_q;

  // Per-frame shadow copies
  logic [15:0] w_sh_q, h_sh_q, hb_sh_q, vb_sh_q, seed_sh_q;
  logic [1:0]  pat_sh_q;

  logic [15:0] x_q, x_d, y_q, y_d, cnt_q, cnt_d, lfsr_q, lfsr_d;

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic valid_q, valid_d, fs_q, fs_d, ls_q, ls_d, fd_q, fd_d;

  logic        run;
  logic        load;  // frame start: capture shadows, seed the LFSR
  logic        last_x, last_y;
  logic [15:0] pix16;
  logic [15:0] lfsr_step;

  assign run       = ctrl_q[0];
  assign last_x    = (x_q == w_sh_q - 16'd1);
  assign last_y    = (y_q == h_sh_q - 16'd1);
  assign lfsr_step = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  always_comb begin
    case (pat_sh_q)
      2'd0:    pix16 = x_q;
      2'd1:    pix16 = y_q;
      2'd2:    pix16 = seed_sh_q;
      default: pix16 = lfsr_q;
    endcase
  end

  // Register file: writes are accepted regardless of en_i
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl_q   <= 3'd0;
      width_q  <= 16'(DEF_WIDTH);
      height_q <= 16'(DEF_HEIGHT);
      hblank_q <= 16'(DEF_HBLANK);
      vblank_q <= 16'(DEF_VBLANK);
      seed_q   <= 16'd0;
    end else if (config_en) begin
      case (config_addr_i)
        3'd0:    ctrl_q   <= config_data_i[2:0];
        3'd1:    width_q  <= config_data_i;
        3'd2:    height_q <= config_data_i;
        3'd3:    hblank_q <= config_data_i;
        3'd4:    vblank_q <= config_data_i;
        3'd5:    seed_q   <= config_data_i;
        default: ;
      endcase
    end
  end

  // Shadows; zero width/height degrade to one
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_sh_q    <= 16'd1;
      h_sh_q    <= 16'd1;
      hb_sh_q   <= 16'd0;
      vb_sh_q   <= 16'd0;
      seed_sh_q <= 16'd0;
      pat_sh_q  <= 2'd0;
    end else if (load) begin
      w_sh_q    <= (width_q == 16'd0) ? 16'd1 : width_q;
      h_sh_q    <= (height_q == 16'd0) ? 16'd1 : height_q;
      hb_sh_q   <= hblank_q;
      vb_sh_q   <= vblank_q;
      seed_sh_q <= seed_q;
      pat_sh_q  <= ctrl_q[2:1];
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    load    = 1'b0;
    data_d  = data_q;
    valid_d = 1'b0;
    fs_d    = 1'b0;
    ls_d    = 1'b0;
    fd_d    = 1'b0;
    if (en_i) begin
      case (state_q)
        StIdle: begin
          if (run) begin
            state_d = StActive;
            load    = 1'b1;
          end
        end
        StActive: begin
          valid_d = 1'b1;
          data_d  = DATA_WIDTH'(pix16);
          ls_d    = (x_q == 16'd0);
          fs_d    = (x_q == 16'd0) && (y_q == 16'd0);
          fd_d    = last_x && last_y;
          lfsr_d  = lfsr_step;
          if (!last_x) begin
            x_d = x_q + 16'd1;
          end else begin
            x_d   = 16'd0;
            cnt_d = 16'd0;
            if (!last_y) begin
              y_d = y_q + 16'd1;
              if (hb_sh_q != 16'd0) state_d = StHblank;
            end else begin
              y_d = 16'd0;
              if (vb_sh_q != 16'd0) state_d = StVblank;
              else if (run)         load    = 1'b1;  // back-to-back frame
              else                  state_d = StIdle;
            end
          end
        end
        StHblank: begin
          if (cnt_q == hb_sh_q - 16'd1) begin
            cnt_d   = 16'd0;
            state_d = StActive;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        StVblank: begin
          if (cnt_q == vb_sh_q - 16'd1) begin
            cnt_d = 16'd0;
            if (run) begin
              state_d = StActive;
              load    = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: state_d = StIdle;
      endcase
      if (load) begin
        x_d    = 16'd0;
        y_d    = 16'd0;
        lfsr_d = (seed_q == 16'd0) ? LfsrInit : seed_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      x_q     <= 16'd0;
      y_q     <= 16'd0;
      cnt_q   <= 16'd0;
      lfsr_q  <= LfsrInit;
      data_q  <= '0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fs_q    <= fs_d;
      ls_q    <= ls_d;
      fd_q    <= fd_d;
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign frame_sync_o = fs_q;
  assign line_sync_o  = ls_q;
  assign frame_done_o = fd_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_raw_stream_tx.sv
// Bench for raw_stream_tx: a frame-level model expands each configured frame into the
// expected per-cycle output stream; one negedge process compares the DUT against it.
module tb_raw_stream_tx;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en_i = 1'b1;
  logic [2:0]  config_addr_i = 3'd0;
  logic [15:0] config_data_i = 16'd0;
  logic        config_en = 1'b0;
  logic [15:0] data_o;
  logic        valid_o, frame_sync_o, line_sync_o, frame_done_o, busy_o;

  raw_stream_tx dut (
    .clk           (clk),
    .rstn          (rstn),
    .en_i          (en_i),
    .config_addr_i (config_addr_i),
    .config_data_i (config_data_i),
    .config_en     (config_en),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .frame_sync_o  (frame_sync_o),
    .line_sync_o   (line_sync_o),
    .frame_done_o  (frame_done_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic        fs;
    logic        ls;
    logic        fd;
    logic        busy;
    logic [15:0] d;
  } ent_t;

  ent_t        q[$];
  logic [15:0] seen[$];
  int          fs_cnt = 0;
  int          n_run = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic        chk = 1'b0;
  logic        en_s = 1'b1;
  logic [15:0] exp_data = 16'd0;
  logic        exp_busy = 1'b0;

  always @(posedge clk) begin
    en_s <= en_i;
    cyc  <= cyc + 1;
  end

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    int unsigned b;
    b = ((s >> 0) ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
    return 16'((int'(s) >> 1) | (b << 15));
  endfunction

  function automatic void push_idle(input logic busy);
    ent_t e;
    e = '0;
    e.busy = busy;
    q.push_back(e);
  endfunction

  // Two leading idle cycles: the CTRL write edge and the IDLE->ACTIVE edge
  function automatic void start_stream();
    push_idle(1'b0);
    push_idle(1'b1);
  endfunction

  function automatic void gen_frame(input int w, input int h, input int hb, input int vb,
                                    input int pat, input logic [15:0] seed);
    int          ww, hh;
    logic [15:0] s;
    ent_t        e;
    ww = (w == 0) ? 1 : w;
    hh = (h == 0) ? 1 : h;
    s  = (seed == 16'd0) ? 16'hACE1 : seed;
    for (int y = 0; y < hh; y++) begin
      for (int x = 0; x < ww; x++) begin
        e.v    = 1'b1;
        e.fs   = (x == 0) && (y == 0);
        e.ls   = (x == 0);
        e.fd   = (x == ww - 1) && (y == hh - 1);
        e.busy = 1'b1;
        case (pat)
          0:       e.d = 16'(x);
          1:       e.d = 16'(y);
          2:       e.d = seed;
          default: e.d = s;
        endcase
        q.push_back(e);
        s = lfsr_next(s);
      end
      if (y < hh - 1) for (int i = 0; i < hb; i++) push_idle(1'b1);
    end
    for (int i = 0; i < vb; i++) push_idle(1'b1);
  endfunction

  // The stream's final cycle is the one that returns the FSM to idle
  function automatic void end_stream();
    ent_t t;
    if (q.size() > 0) begin
      t = q[q.size()-1];
      t.busy = 1'b0;
      q[q.size()-1] = t;
    end
  endfunction

  always @(negedge clk) begin
    if (chk) begin
      ent_t e;
      logic dchk;
      if (!en_s) begin
        e = '0;
        e.busy = exp_busy;
        e.d = exp_data;
        dchk = 1'b1;
      end else if (q.size() != 0) begin
        e = q.pop_front();
        dchk = e.v;
      end else begin
        e = '0;
        dchk = 1'b0;
      end
      if (e.v) exp_data = e.d;
      exp_busy = e.busy;
      n_run++;
      if (valid_o !== e.v || frame_sync_o !== e.fs || line_sync_o !== e.ls ||
          frame_done_o !== e.fd || busy_o !== e.busy || (dchk && data_o !== e.d)) begin
        n_fail++;
        $display("FAIL stream cyc %0d: got v%b fs%b ls%b fd%b busy%b d=%h, want v%b fs%b ls%b fd%b busy%b d=%h",
                 cyc, valid_o, frame_sync_o, line_sync_o, frame_done_o, busy_o, data_o,
                 e.v, e.fs, e.ls, e.fd, e.busy, e.d);
      end
      if (valid_o) seen.push_back(data_o);
      if (frame_sync_o) fs_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_run++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, expv);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    config_addr_i = a;
    config_data_i = d;
    config_en = 1'b1;
    tick();
    config_en = 1'b0;
  endtask

  task automatic cfg(input int w, input int h, input int hb, input int vb);
    wr(3'd1, 16'(w));
    wr(3'd2, 16'(h));
    wr(3'd3, 16'(hb));
    wr(3'd4, 16'(vb));
  endtask

  task automatic do_reset();
    chk = 1'b0;
    rstn = 1'b0;
    en_i = 1'b1;
    config_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    q.delete();
    seen.delete();
    fs_cnt = 0;
    exp_data = 16'd0;
    exp_busy = 1'b0;
    chk = 1'b1;
  endtask

  task automatic wait_seen(input int n, input int budget);
    int k = 0;
    while (seen.size() < n && k < budget) begin tick(); k++; end
    if (seen.size() < n) lit("wait_seen timeout", 32'(seen.size()), 32'(n));
  endtask

  task automatic wait_fs(input int n, input int budget);
    int k = 0;
    while (fs_cnt < n && k < budget) begin tick(); k++; end
    if (fs_cnt < n) lit("wait_fs timeout", 32'(fs_cnt), 32'(n));
  endtask

  task automatic wait_empty(input int budget);
    int k = 0;
    while (q.size() != 0 && k < budget) begin tick(); k++; end
    if (q.size() != 0) lit("wait_empty timeout", 32'(q.size()), 32'd0);
    repeat (6) tick();
  endtask

  task automatic chk_ramp8(input string name);
    logic [15:0] expv [8] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0, 16'd1, 16'd2, 16'd3};
    for (int i = 0; i < 8; i++) lit(name, (i < seen.size()) ? 32'(seen[i]) : 32'hDEAD, 32'(expv[i]));
  endtask

  initial begin
    // Reset state
    do_reset();
    lit("reset outputs", {valid_o, frame_sync_o, line_sync_o, frame_done_o, busy_o, data_o},
        32'd0);
    repeat (3) tick();

    // Horizontal ramp, 4x2, HB=2, VB=1, two frames then RUN cleared
    do_reset();
    cfg(4, 2, 2, 1);
    wr(3'd0, 16'h0001);
    lit("busy before start", 32'(busy_o), 32'd0);
    start_stream();
    gen_frame(4, 2, 2, 1, 0, 16'd0);
    gen_frame(4, 2, 2, 1, 0, 16'd0);
    end_stream();
    wait_fs(2, 100);
    wr(3'd0, 16'h0000);
    wait_empty(200);
    chk_ramp8("hramp pixels");
    lit("hramp frame count", 32'(fs_cnt), 32'd2);

    // en_i low for three cycles mid-line
    do_reset();
    cfg(4, 2, 2, 1);
    wr(3'd0, 16'h0001);
    start_stream();
    gen_frame(4, 2, 2, 1, 0, 16'd0);
    end_stream();
    wait_seen(2, 50);
    en_i = 1'b0;
    repeat (3) tick();
    en_i = 1'b1;
    wr(3'd0, 16'h0000);
    wait_empty(200);
    chk_ramp8("stall pixels");
    lit("stall pixel count", 32'(seen.size()), 32'd8);

    // Vertical ramp, no blanking, back-to-back frames
    do_reset();
    cfg(3, 2, 0, 0);
    wr(3'd0, 16'h0003);
    start_stream();
    for (int f = 0; f < 3; f++) gen_frame(3, 2, 0, 0, 1, 16'd0);
    end_stream();
    wait_fs(3, 100);
    wr(3'd0, 16'h0002);
    wait_empty(200);
    begin
      logic [15:0] vexp [9] = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0};
      for (int i = 0; i < 9; i++)
        lit("vramp pixels", (i < seen.size()) ? 32'(seen[i]) : 32'hDEAD, 32'(vexp[i]));
    end

    // Constant pattern, WIDTH rewritten mid-frame
    do_reset();
    cfg(4, 2, 2, 1);
    wr(3'd5, 16'h00A5);
    wr(3'd0, 16'h0005);
    start_stream();
    gen_frame(4, 2, 2, 1, 2, 16'h00A5);
    gen_frame(8, 2, 2, 1, 2, 16'h00A5);
    end_stream();
    wait_seen(2, 50);
    wr(3'd1, 16'd8);
    wait_fs(2, 100);
    wr(3'd0, 16'h0004);
    wait_empty(200);
    lit("width change pixel count", 32'(seen.size()), 32'd24);
    lit("constant value", (seen.size() > 0) ? 32'(seen[0]) : 32'hDEAD, 32'h00A5);

    // RUN cleared at frame pixel 2
    do_reset();
    cfg(4, 2, 2, 1);
    wr(3'd0, 16'h0001);
    start_stream();
    gen_frame(4, 2, 2, 1, 0, 16'd0);
    end_stream();
    wait_seen(2, 50);
    wr(3'd0, 16'h0000);
    wait_empty(200);
    lit("run clear busy", 32'(busy_o), 32'd0);
    lit("run clear pixel count", 32'(seen.size()), 32'd8);

    // LFSR, SEED=0; RUN cleared the very cycle the FSM samples it
    do_reset();
    cfg(4, 2, 2, 1);
    wr(3'd5, 16'h0000);
    wr(3'd0, 16'h0007);
    start_stream();
    gen_frame(4, 2, 2, 1, 3, 16'd0);
    end_stream();
    wr(3'd0, 16'h0006);
    wait_empty(200);
    lit("lfsr pixel 0", (seen.size() > 0) ? 32'(seen[0]) : 32'hDEAD, 32'hACE1);
    lit("lfsr pixel 1", (seen.size() > 1) ? 32'(seen[1]) : 32'hDEAD, 32'h5670);

    // Asynchronous reset mid-line, then defaults
    do_reset();
    cfg(4, 2, 2, 1);
    wr(3'd5, 16'h0055);
    wr(3'd0, 16'h0001);
    start_stream();
    gen_frame(4, 2, 2, 1, 0, 16'd0);
    wait_seen(2, 50);
    @(posedge clk);
    #3 chk = 1'b0;
    rstn = 1'b0;
    #1;
    lit("async reset outputs",
        {valid_o, frame_sync_o, line_sync_o, frame_done_o, busy_o, data_o}, 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    q.delete();
    seen.delete();
    fs_cnt = 0;
    exp_data = 16'd0;
    exp_busy = 1'b0;
    chk = 1'b1;
    repeat (10) tick();
    lit("run after reset", 32'(seen.size()), 32'd0);
    wr(3'd0, 16'h0001);
    start_stream();
    gen_frame(64, 48, 16, 8, 0, 16'd0);
    end_stream();
    wr(3'd0, 16'h0000);
    wait_empty(5000);
    lit("default frame pixels", 32'(seen.size()), 32'd3072);
    lit("default last x", (seen.size() > 63) ? 32'(seen[63]) : 32'hDEAD, 32'd63);

    chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/raw_stream_tx.md
Name: raw_stream_tx

Overview:
- Raw-domain video stream transmitter. Drives the pixel-stream side of the RAWDNS pipeline: data, valid, frame_sync and line_sync, into stage inputs such as the NLM denoiser's data_i/valid_i/frame_sync_i/line_sync_i.
- Generates programmable frame timing (width, height, horizontal and vertical blanking) and a selectable test pattern, configured over the 3-bit-address/16-bit-data config bus used across RAWDNS.
- Used as the stream source for block-level benches and for in-system pattern injection.

Parameters:
- DATA_WIDTH, 16, pixel width on data_o.
- DEF_WIDTH, 64, reset value of the WIDTH register (pixels per line).
- DEF_HEIGHT, 48, reset value of the HEIGHT register (lines per frame).
- DEF_HBLANK, 16, reset value of HBLANK (idle cycles between lines).
- DEF_VBLANK, 8, reset value of VBLANK (idle cycles after the last line of a frame).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- en_i  in  1  global advance enable; low freezes the block.
- config_addr_i  in  3  register address.
- config_data_i  in  16  register write data.
- config_en  in  1  register write strobe, one cycle per write.
- data_o  out  DATA_WIDTH  pixel value; meaningful only when valid_o=1.
- valid_o  out  1  pixel qualifier.
- frame_sync_o  out  1  one-cycle pulse coincident with the first valid pixel of a frame.
- line_sync_o  out  1  one-cycle pulse coincident with the first valid pixel of every line, including line 0.
- frame_done_o  out  1  one-cycle pulse coincident with the last valid pixel of a frame.
- busy_o  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Register map. All registers are 16 bit and written on config_en, independent of en_i. Writes to addresses 6 and 7 are ignored.
  - 0 CTRL: bit0 RUN; bits[2:1] PAT, where 0 = horizontal ramp, 1 = vertical ramp, 2 = constant, 3 = LFSR.
  - 1 WIDTH.
  - 2 HEIGHT.
  - 3 HBLANK.
  - 4 VBLANK.
  - 5 SEED. Holds the constant value for PAT=2 and the LFSR seed for PAT=3.
  - Reset values: CTRL=0, SEED=0, other registers take their DEF_* parameters.
- Shadowing: WIDTH, HEIGHT, HBLANK, VBLANK, PAT and SEED are copied to shadow registers at each frame start (IDLE->ACTIVE or VBLANK->ACTIVE). Mid-frame writes take effect only at the next frame. A WIDTH or HEIGHT value of 0 is treated as 1.
- Reset: all outputs are 0; FSM=IDLE; x, y and blank counters are 0; LFSR=16'hACE1.
- FSM states: IDLE, ACTIVE, HBLANK, VBLANK.
  - IDLE -> ACTIVE when RUN=1 and en_i=1. Shadows load on this transition.
  - ACTIVE: one pixel per en_i cycle; x increments.
    - At x=W-1 and y<H-1: go to HBLANK, or stay in ACTIVE for the next line if HBLANK=0. x clears and y increments.
    - At x=W-1 and y=H-1: go to VBLANK, or start the next frame directly if VBLANK=0 and RUN=1, or go to IDLE if VBLANK=0 and RUN=0.
  - HBLANK: count HBLANK cycles, then go to ACTIVE.
  - VBLANK: count VBLANK cycles, then go to ACTIVE (new frame, shadows reload) if RUN=1, else go to IDLE.
  - Clearing RUN mid-frame never truncates a frame. The current frame and its VBLANK complete before the FSM returns to IDLE.
- en_i=0: state, counters and LFSR hold. valid_o and all sync/done outputs are 0 for that cycle; data_o holds. Blank counters also count only on en_i=1 cycles.
- All outputs are registered.
  - A CTRL write setting RUN at cycle T (en_i high throughout) gives FSM=ACTIVE at T+1 and valid_o=frame_sync_o=line_sync_o=1 at T+2.
  - Pixels within a line are on consecutive en_i cycles with no gaps.
- Pattern values, truncated or zero-extended to DATA_WIDTH:
  - Horizontal ramp: x.
  - Vertical ramp: y.
  - Constant: SEED.
  - LFSR: 16-bit Fibonacci, taps 16,14,13,11. It loads the seed at frame start, with SEED=0 replaced by 16'hACE1. The first pixel outputs the seed value, and the LFSR advances after each valid pixel.
- Simultaneous events:
  - A CTRL write in the cycle the FSM evaluates RUN is not seen until the next cycle.
  - frame_sync, line_sync and frame_done are all high together for a 1x1 frame.
- Asynchronous reset mid-frame returns the block to the reset state immediately. Registers revert to their defaults, so RUN=0.

Test Plan:
- WIDTH=4, HEIGHT=2, HBLANK=2, VBLANK=1, PAT=0, RUN=1 -> data_o 0,1,2,3, then 2 idle cycles, then 0,1,2,3.
  - line_sync_o on each first pixel; frame_sync_o only on the first; frame_done_o on the 8th pixel.
  - After 1 idle cycle, the next frame begins.
- Same setup, en_i low for 3 cycles at pixel x=1 -> valid_o low for 3 cycles, then the sequence resumes at x=2 with no lost or duplicated pixels.
- HBLANK=0, VBLANK=0, WIDTH=3, HEIGHT=2, PAT=1 -> continuous valid_o; data_o 0,0,0,1,1,1,0,0,0,...
- WIDTH=4 written to 8 mid-frame -> the current frame stays 4 wide; the next frame's lines are 8 pixels.
- RUN cleared at frame pixel 2 -> the frame completes; busy_o falls after VBLANK; no further valid_o.
- PAT=3, SEED=0 -> first pixel 16'hACE1, second pixel 16'h5670. Also check rstn pulsed mid-line -> all outputs 0 that cycle and registers return to defaults.
